// File: rtl/noc_xy_router.sv
// Five-port XY mesh router: per-input FIFOs, dimension-ordered routing, round-robin output arbiters, registered outputs.
// Defining NOC_ROUTER_STATS_EN builds a 16-bit delivered-flit counter per output; otherwise stat_cnt_o is tied to 0.
module noc_xy_router #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int XW    = 2,
  parameter int YW    = 2,
  parameter int X_ID  = 0,
  parameter int Y_ID  = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [5*DW-1:0] in_data_i,
  input  logic [4:0]      in_valid_i,
  output logic [4:0]      in_ready_o,
  output logic [5*DW-1:0] out_data_o,
  output logic [4:0]      out_valid_o,
  input  logic [4:0]      out_ready_i,
  output logic [5*16-1:0] stat_cnt_o
);

  localparam int NP = 5;
  localparam int AW = $clog2(DEPTH);
  localparam logic [XW-1:0] X_ME = XW'(X_ID);
  localparam logic [YW-1:0] Y_ME = YW'(Y_ID);

  typedef enum logic [2:0] {
    P_LOCAL = 3'd0,
    P_EAST  = 3'd1,
    P_WEST  = 3'd2,
    P_NORTH = 3'd3,
    P_SOUTH = 3'd4
  } port_e;

  logic [DW-1:0] mem_q    [NP][DEPTH];
  logic [AW-1:0] wr_ptr_q [NP];
  logic [AW-1:0] rd_ptr_q [NP];
  logic [AW:0]   count_q  [NP];
  logic [2:0]    rr_ptr_q [NP];
  logic [DW-1:0] out_data_q [NP];
  logic [NP-1:0] out_valid_q;

  logic [DW-1:0] head    [NP];
  logic [2:0]    dst     [NP];
  logic [2:0]    gnt_idx [NP];
  logic [NP-1:0] gnt_vld;
  logic [NP-1:0] nonempty;
  logic [NP-1:0] push;
  logic [NP-1:0] pop;
  logic [NP-1:0] out_free;

  function automatic logic [2:0] xy_route(input logic [XW+YW-1:0] addr);
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    dx = addr[XW-1:0];
    dy = addr[XW+YW-1:XW];
    if (dx > X_ME)      return P_EAST;
    else if (dx < X_ME) return P_WEST;
    else if (dy > Y_ME) return P_NORTH;
    else if (dy < Y_ME) return P_SOUTH;
    else                return P_LOCAL;
  endfunction

  // in_ready depends on full only, so a pop in the same cycle never re-opens a full FIFO.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      head[i]       = mem_q[i][rd_ptr_q[i]];
      nonempty[i]   = (count_q[i] != '0);
      in_ready_o[i] = (count_q[i] != (AW+1)'(DEPTH));
      push[i]       = in_valid_i[i] & in_ready_o[i];
      dst[i]        = xy_route(head[i][XW+YW-1:0]);
    end
  end

  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    int idx;
    idx = 0;
    pop = '0;
    for (int o = 0; o < NP; o++) begin
      gnt_vld[o]  = 1'b0;
      gnt_idx[o]  = '0;
      out_free[o] = !out_valid_q[o] | out_ready_i[o];
      for (int k = 0; k < NP; k++) begin
        idx = int'(rr_ptr_q[o]) + k;
        if (idx >= NP) idx = idx - NP;
        if (out_free[o] && !gnt_vld[o] && nonempty[idx] && dst[idx] == 3'(o)) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = 3'(idx);
          pop[idx]   = 1'b1;
        end
      end
    end
  end

  // NOTE: FIFO storage has no reset; count_q gates every read, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NP; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data_i[i*DW +: DW];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NP; i++) begin
        wr_ptr_q[i]   <= '0;
        rd_ptr_q[i]   <= '0;
        count_q[i]    <= '0;
        rr_ptr_q[i]   <= '0;
        out_data_q[i] <= '0;
      end
      out_valid_q <= '0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        count_q[i] <= count_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end
      for (int o = 0; o < NP; o++) begin
        if (gnt_vld[o]) begin
          out_data_q[o]  <= head[gnt_idx[o]];
          out_valid_q[o] <= 1'b1;
          rr_ptr_q[o]    <= (gnt_idx[o] == 3'd4) ? 3'd0 : gnt_idx[o] + 3'd1;
        end else if (out_ready_i[o]) begin
          out_valid_q[o] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NP; o++) out_data_o[o*DW +: DW] = out_data_q[o];
    out_valid_o = out_valid_q;
  end

`ifdef NOC_ROUTER_STATS_EN
  logic [15:0] stat_q [NP];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int o = 0; o < NP; o++) stat_q[o] <= '0;
    end else begin
      for (int o = 0; o < NP; o++) begin
        if (out_valid_q[o] & out_ready_i[o]) stat_q[o] <= stat_q[o] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NP; o++) stat_cnt_o[o*16 +: 16] = stat_q[o];
  end
`else
  assign stat_cnt_o = '0;
`endif

endmodule

// File: doc/noc_xy_router.md
# noc_xy_router

Parametrised five-port mesh router: local, east, west, north and south. Each input port has a FIFO buffer with a valid/ready handshake. Each head flit is routed with dimension-ordered XY routing, computed from the router's own mesh coordinates. Each output is driven by a round-robin arbiter and a registered output stage. The block replaces the fixed 8-bit, fixed-route router as the tile switch in the NoC mesh, with one instance per tile.

## Interface
- DW, 8: flit width in bits; must satisfy DW ≥ XW+YW.
- DEPTH, 4: entries per input FIFO; power of two, ≥ 2.
- XW, 2: width of the X coordinate field.
- YW, 2: width of the Y coordinate field.
- X_ID, 0: this router's X coordinate.
- Y_ID, 0: this router's Y coordinate.
- Port index mapping, used for every 5-wide vector: 0 local, 1 east, 2 west, 3 north, 4 south.
- Clk  in  1  single clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- in_data  in  5*DW  input flits; port p occupies bits [p*DW +: DW].
- in_valid  in  5  input flit valid.
- in_ready  out  5  input FIFO can accept a flit.
- out_data  out  5*DW  output flits, same packing as in_data.
- out_valid  out  5  output register holds a flit.
- out_ready  in  5  downstream accepts the flit.
- stat_cnt  out  5*16  flits delivered per output (see Configuration).

## Operation
- Flit format: bits [XW-1:0] hold the destination X; bits [XW+YW-1:XW] hold the destination Y. Every flit is a complete single-flit packet.
- Input FIFO push: occurs when in_valid[p] & in_ready[p]; in_ready[p] = !full[p]. There is no fall-through, so in_ready stays low when full even if a pop occurs in the same cycle.
- Route of a non-empty FIFO head, first matching rule wins:
  - dest X > X_ID → east.
  - dest X < X_ID → west.
  - dest Y > Y_ID → north.
  - dest Y < Y_ID → south.
  - otherwise → local.
- Output o is free when !out_valid[o] | out_ready[o].
- Arbiter o considers only the inputs requesting o, and only while o is free.
- The arbiter grants the first requester at or after its pointer, scanning indices ascending and wrapping 4→0.
- On a grant to input i: pointer ← (i+1) mod 5. Without a grant, the pointer holds.
- On a grant: the head of input i is popped and loaded into output register o, and out_valid[o] ← 1 in the same edge.
- An input can be granted by at most one output per cycle, since each head routes to exactly one output.
- Output o with out_valid & out_ready and no new grant: out_valid[o] ← 0.
- Output data is held stable while out_valid & !out_ready.

## Timing
- Reset values:
  - in_ready = 5'b11111 (in_ready is combinational from full).
  - out_valid = 0.
  - out_data = 0.
  - stat_cnt = 0.
  - FIFOs empty.
  - All arbiter pointers = 0.
- Reset asserted mid-operation discards all buffered and in-flight flits immediately (asynchronous). There is no partial state after deassertion.
- Latency: a flit pushed at edge t appears with out_valid at edge t+1 when its output is free and the flit wins arbitration. Minimum is one cycle input-to-output.
- Throughput: one flit per output per cycle when out_ready is held high.
- Simultaneous push and pop on a non-full FIFO: both happen, and the count is unchanged.
- FIFO pointers wrap modulo DEPTH.
- The count is DEPTH-accurate, with a distinct full and empty.
- Backpressure: out_ready low blocks that output only. Heads targeting other outputs proceed, except behind a blocked head in the same FIFO (head-of-line blocking is accepted).

## Configuration
- Macro: NOC_ROUTER_STATS_EN.
- Defined:
  - stat_cnt[o*16 +: 16] increments by 1 on every out_valid[o] & out_ready[o] handshake.
  - The counter wraps from 16'hFFFF to 0.
  - Reset clears it to 0.
- Undefined:
  - No counter logic is built.
  - stat_cnt is tied to 0.

## Test plan
- Local ejection, with X_ID=1, Y_ID=1: inject 8'h05 (X=1, Y=1) on east → the flit appears on out_data[0 +: 8] one cycle later; no other out_valid rises.
- XY order, with X_ID=1, Y_ID=1: inject 8'h0B (X=3, Y=2) on local → east output. Inject 8'h09 (X=1, Y=2) → north output. Inject 8'h01 (X=1, Y=0) → south output.
- Round-robin fairness: all four non-local inputs stream flits to local with out_ready=1 → grants rotate 1,2,3,4,1,… and each input gets exactly 25 of 100 flits.
- Backpressure/full, with DEPTH=4: hold out_ready[1]=0 and push 6 east-bound flits on local → one flit sits in the output register, 4 fill the FIFO, and in_ready[0]=0 from then on. Release out_ready → all 5 flits exit in order, one per cycle.
- Reset mid-stream: assert Rst with 3 flits buffered → out_valid=0 and in_ready=5'b11111 immediately. After release, no stale flit is ever emitted.
- Stats, with NOC_ROUTER_STATS_EN defined: deliver 65537 flits through west → stat_cnt[2*16 +: 16]=1. Without the macro → that field stays 0.
